xnor_serial_cmp: RTL and testbench
==================================

# xnor_serial_cmp

Bit-serial word comparator controller that owns a single 1-bit `xnor_gate` cell and sequences it across all bit positions of two latched operands. It reports the number of matching bit positions, a word-equality flag and a threshold pass flag. The block sits between a requesting controller, using a start/busy/done handshake, and the shared 1-bit XNOR datapath. It trades WIDTH cycles of latency for one gate of comparison logic.

## Interface
- `WIDTH`, default 8: operand width in bits; legal range is WIDTH ≥ 2.
- `CNT_W`, derived as $clog2(WIDTH+1), not overridable: count width; 4 for WIDTH=8.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: reset, **synchronous and active-high**.
- `start`  in  1: request; sampled only in IDLE.
- `a_in`  in  WIDTH: operand A; sampled with `start`.
- `b_in`  in  WIDTH: operand B; sampled with `start`.
- `thresh`  in  CNT_W: match threshold; sampled with `start`.
- `busy`  out  1: high while bits are being processed.
- `done`  out  1: one-cycle completion pulse.
- `match_cnt`  out  CNT_W: number of bit positions where A equals B.
- `equal`  out  1: high when match_cnt == WIDTH.
- `pass`  out  1: high when match_cnt ≥ latched thresh.

## Operation
- FSM states: IDLE (2'b00), RUN (2'b01), DONE (2'b10). Encoding 2'b11 is illegal and returns to IDLE on the next edge.
- **IDLE**, on `start`=1:
  - Latch `a_in`, `b_in` and `thresh` into internal shift and threshold registers.
  - Clear the running count and the bit index.
  - Move to RUN.
- **RUN**, one bit per cycle:
  - The LSBs of the A and B shift registers drive `xnor_gate`.
  - If its output y=1, the running count increments.
  - Both shift registers shift right by one.
  - The bit index increments.
- **RUN exit**: the cycle with index == WIDTH-1 is the last bit. On that edge:
  - The final count, including the last bit, is written to `match_cnt`.
  - `equal` and `pass` are computed from that final count and registered.
  - The FSM moves to DONE.
- **DONE**: `done`=1 for exactly one cycle, then the FSM returns to IDLE unconditionally.
- `start` in RUN or DONE is ignored; no queuing.
- Changes on `a_in`, `b_in` or `thresh` after the start cycle have no effect on the operation in progress.
- Results hold their values until the next DONE entry or reset.
- Arithmetic rules:
  - The running count never exceeds WIDTH; no wrap-around.
  - `thresh`=0 gives `pass`=1 always.
  - `thresh` > WIDTH gives `pass`=0 always.
- Reset values: state IDLE, and `busy`, `done`, `match_cnt`, `equal`, `pass`, shift registers, index and threshold register all 0.
- Reset mid-RUN or in DONE: the operation is aborted, no `done` pulse, and all outputs return to their reset values on that edge.
- Reset and `start` in the same cycle: reset wins; the start is lost.

## Timing
- `start` sampled at edge E0 (cycle 0):
  - `busy`=1 in cycles 1..WIDTH.
  - `done`=1 in cycle WIDTH+1.
  - IDLE again in cycle WIDTH+2.
- Latency from start to done is WIDTH+1 cycles.
- Minimum start-to-start spacing is WIDTH+2 cycles; a new `start` is first accepted in cycle WIDTH+2.
- `match_cnt`, `equal` and `pass` become valid in the same cycle as `done`.
- All outputs are registered; there is no combinational path from inputs to outputs.
- `busy` and `done` are never high in the same cycle.

## Structure
- Shared package/include `xnor_cmp_pkg`:
  - State encoding constants ST_IDLE, ST_RUN, ST_DONE.
  - CNT_W derivation helper (clog2).
- One sub-module: an instance of the existing `xnor_gate` cell as the only comparison datapath. No other XNOR or equality logic is permitted on the operands.
- Everything else is in the top: FSM, shift registers, bit index counter, match counter and output registers.

## Test plan
- **Full match**: WIDTH=8, a=0xA5, b=0xA5, thresh=8, start in cycle 0 -> `done` in cycle 9, `match_cnt`=8, `equal`=1, `pass`=1; `busy` high in cycles 1–8 only.
- **No match**: a=0xFF, b=0x00, thresh=0 -> `match_cnt`=0, `equal`=0, `pass`=1.
- **Threshold edge**: a=0xF0, b=0xFF.
  - thresh=5 -> `match_cnt`=4, `pass`=0.
  - Rerun with thresh=4 -> `pass`=1.
  - Rerun with thresh=9 -> `pass`=0.
- **Protocol**: `start` held high continuously while `a_in` toggles every cycle.
  - Exactly one `done` per WIDTH+2 cycles.
  - Results match the operands latched at each accepted start.
  - A `start` pulse in RUN is ignored.
- **Reset mid-operation**: `rst`=1 in cycle 3 of RUN -> next cycle `busy`=0, all outputs 0, no `done`. A following start with a=0x0F, b=0x0E completes with `match_cnt`=7.
- **Back-to-back**: second `start` in cycle 10 (first IDLE cycle) with a=0x00, b=0x00 -> accepted; second `done` in cycle 19 with `match_cnt`=8, `equal`=1.

Source files
------------

// File: rtl/xnor_cmp_pkg.sv
// Shared definitions for the bit-serial XNOR word comparator.
package xnor_cmp_pkg;

  // FSM state encoding. 2'b11 is unused and recovers to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } cmp_state_e;

  // Width of a counter that must hold the values 0..width inclusive.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/xnor_gate.sv
// Single-bit XNOR cell; the only comparison logic in the serial comparator.
module xnor_gate (
  input  logic a,
  input  logic b,
  output logic y
);

  assign y = ~(a ^ b);

endmodule

// File: rtl/xnor_serial_cmp.sv
// Bit-serial word comparator: walks one shared XNOR cell across WIDTH bit
// positions, then reports the match count, word equality and threshold pass.
module xnor_serial_cmp
  import xnor_cmp_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [CNT_W-1:0] thresh,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] match_cnt,
  output logic             equal,
  output logic             pass
);

  localparam logic [CNT_W-1:0] LastIdx  = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] FullCnt  = CNT_W'(WIDTH);

  cmp_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [CNT_W-1:0] thr_q, thr_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
  logic             equal_q, equal_d;
  logic             pass_q, pass_d;

  logic             bit_match;
  logic [CNT_W-1:0] cnt_next;

  xnor_gate u_xnor_gate (
    .a (a_sr_q[0]),
    .b (b_sr_q[0]),
    .y (bit_match)
  );

  // Next-state and datapath update; results only change on DONE entry.
  always_comb begin
    state_d     = state_q;
    a_sr_d      = a_sr_q;
    b_sr_d      = b_sr_q;
    thr_d       = thr_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    match_cnt_d = match_cnt_q;
    equal_d     = equal_q;
    pass_d      = pass_q;
    // Count including the bit currently on the gate; never exceeds WIDTH.
    cnt_next    = cnt_q + CNT_W'(bit_match);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_sr_d  = a_in;
          b_sr_d  = b_in;
          thr_d   = thresh;
          cnt_d   = '0;
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        idx_d  = idx_q + CNT_W'(1);
        cnt_d  = cnt_next;
        if (idx_q == LastIdx) begin
          match_cnt_d = cnt_next;
          equal_d     = (cnt_next == FullCnt);
          // Thresholds above WIDTH can never be reached, so fail naturally.
          pass_d      = (cnt_next >= thr_q);
          state_d     = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register with synchronous reset; reset aborts any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      a_sr_q      <= '0;
      b_sr_q      <= '0;
      thr_q       <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      match_cnt_q <= '0;
      equal_q     <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sr_q      <= a_sr_d;
      b_sr_q      <= b_sr_d;
      thr_q       <= thr_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      match_cnt_q <= match_cnt_d;
      equal_q     <= equal_d;
      pass_q      <= pass_d;
    end
  end

  // Handshake flags decode straight from the state register.
  always_comb begin
    busy      = (state_q == ST_RUN);
    done      = (state_q == ST_DONE);
    match_cnt = match_cnt_q;
    equal     = equal_q;
    pass      = pass_q;
  end

endmodule

// File: tb/tb_xnor_serial_cmp.sv
// Self-checking bench for xnor_serial_cmp: directed cases plus random operands
// against a bit-counting reference model.
module tb_xnor_serial_cmp;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W-1:0]  a_in;
  logic [W-1:0]  b_in;
  logic [CW-1:0] thresh;
  logic          busy;
  logic          done;
  logic [CW-1:0] match_cnt;
  logic          equal;
  logic          pass;

  int n_checks = 0;
  int n_fail   = 0;

  xnor_serial_cmp #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a_in      (a_in),
    .b_in      (b_in),
    .thresh    (thresh),
    .busy      (busy),
    .done      (done),
    .match_cnt (match_cnt),
    .equal     (equal),
    .pass      (pass)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: number of bit positions where the two words agree.
  function automatic int ref_cnt(input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    for (int i = 0; i < W; i++) if (a[i] == b[i]) n++;
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Call from an IDLE cycle; returns in the first IDLE cycle after done.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [CW-1:0] th);
    int exp_cnt;
    exp_cnt = ref_cnt(a, b);
    start = 1'b1; a_in = a; b_in = b; thresh = th;
    tick();
    start = 1'b0; a_in = W'($urandom); b_in = W'($urandom); thresh = CW'($urandom);
    for (int c = 1; c <= W; c++) begin
      check("busy_run", busy, 1);
      check("done_run", done, 0);
      // Stray request mid-run must be ignored.
      if (c == 3) begin
        start = 1'b1; a_in = W'($urandom); b_in = W'($urandom);
      end else begin
        start = 1'b0;
      end
      tick();
    end
    check("done_pulse", done, 1);
    check("busy_done", busy, 0);
    check("match_cnt", match_cnt, exp_cnt);
    check("equal", equal, (exp_cnt == W) ? 1 : 0);
    check("pass", pass, (exp_cnt >= int'(th)) ? 1 : 0);
    tick();
    check("done_single", done, 0);
    check("busy_idle", busy, 0);
    check("match_hold", match_cnt, exp_cnt);
  endtask

  initial begin
    logic [W-1:0]  lat_a, lat_b, b_fix;
    logic [CW-1:0] lat_t;
    int            phase, n_done;

    rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0; thresh = '0;
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cnt", match_cnt, 0);
    check("rst_equal", equal, 0);
    check("rst_pass", pass, 0);
    rst = 1'b0;
    tick();

    // Directed: full match then back-to-back all-zero pair.
    do_op(8'hA5, 8'hA5, 4'd8);
    do_op(8'h00, 8'h00, 4'd3);
    do_op(8'hFF, 8'h00, 4'd0);
    do_op(8'hF0, 8'hFF, 4'd5);
    do_op(8'hF0, 8'hFF, 4'd4);
    do_op(8'hF0, 8'hFF, 4'd9);
    do_op(8'h5A, 8'h5A, 4'd15);

    // start held high, a_in changing every cycle: one op per W+2 cycles.
    n_done = 0;
    b_fix  = W'($urandom);
    lat_a = '0; lat_b = '0; lat_t = '0;
    for (int n = 0; n < 3 * (W + 2); n++) begin
      phase  = n % (W + 2);
      start  = 1'b1;
      a_in   = W'($urandom);
      b_in   = b_fix;
      thresh = CW'($urandom_range(0, 9));
      if (phase == 0) begin
        lat_a = a_in; lat_b = b_in; lat_t = thresh;
      end
      tick();
      check("proto_busy", busy, (phase < W) ? 1 : 0);
      check("proto_done", done, (phase == W) ? 1 : 0);
      if (done) n_done++;
      if (phase == W) begin
        check("proto_cnt", match_cnt, ref_cnt(lat_a, lat_b));
        check("proto_pass", pass, (ref_cnt(lat_a, lat_b) >= int'(lat_t)) ? 1 : 0);
      end
    end
    start = 1'b0;
    check("proto_ndone", n_done, 3);

    // Reset in the third RUN cycle aborts with outputs cleared.
    do_op(8'hA5, 8'hA5, 4'd8);
    start = 1'b1; a_in = 8'h33; b_in = 8'h33; thresh = 4'd1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_cnt", match_cnt, 0);
    check("abort_equal", equal, 0);
    check("abort_pass", pass, 0);
    for (int c = 0; c < W + 2; c++) begin
      tick();
      check("abort_nodone", done, 0);
    end
    do_op(8'h0F, 8'h0E, 4'd7);

    // Reset and start together: start is lost.
    rst = 1'b1; start = 1'b1; a_in = 8'h12; b_in = 8'h12;
    tick();
    rst = 1'b0; start = 1'b0;
    check("rststart_busy", busy, 0);
    tick();
    check("rststart_busy2", busy, 0);
    check("rststart_cnt", match_cnt, 0);

    for (int k = 0; k < 25; k++) begin
      do_op(W'($urandom), W'($urandom), CW'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
